mdu_ctrl: RTL and testbench

- Sequencing controller and result holder for the multiply/divide unit in the 5-stage MIPS pipeline.
- Accepts one operation per start pulse from stage E and models the fixed multi-cycle latency with a busy counter.
- Owns the HI/LO registers.
- Drives the stall request back to stage D so that mult/div/mfhi/mflo/mthi/mtlo cannot issue while the unit is occupied.

---
 rtl/mdu_ctrl.sv | 134 +++++++++++++
 tb/tb_mdu_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: models fixed mult/div latency with a busy counter,
// owns HI/LO, and raises the D-stage stall while the unit is occupied.
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  MDOp_E,
   input  logic        Start_E,
   input  logic [31:0] A_E,
   input  logic [31:0] B_E,
   input  logic        MD_D,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Stall_MD
);

   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   logic        mul_signed, div_signed, b_zero;
   logic [63:0] ext_a, ext_b, prod;
   logic [31:0] a_mag, b_mag, uq, ur, quot, rem;
   logic        start_md;

   // Signed division is done on magnitudes so INT_MIN / -1 wraps instead of overflowing.
   always_comb begin
      mul_signed = (op_q == OpMult);
      div_signed = (op_q == OpDiv);
      b_zero     = (b_q == 32'd0);
      ext_a      = {{32{mul_signed & a_q[31]}}, a_q};
      ext_b      = {{32{mul_signed & b_q[31]}}, b_q};
      prod       = ext_a * ext_b;
      a_mag      = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
      b_mag      = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
      uq         = a_mag / (b_zero ? 32'd1 : b_mag);
      ur         = a_mag % (b_zero ? 32'd1 : b_mag);
      quot       = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
      rem        = (div_signed && a_q[31]) ? (32'd0 - ur) : ur;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         StIdle: begin
            if (Start_E) begin
               case (MDOp_E)
                  OpMult, OpMultu: begin
                     state_d = StRun;
                     cnt_d   = 4'(MULT_CYCLES);
                     op_d    = MDOp_E;
                     a_d     = A_E;
                     b_d     = B_E;
                  end
                  OpDiv, OpDivu: begin
                     state_d = StRun;
                     cnt_d   = 4'(DIV_CYCLES);
                     op_d    = MDOp_E;
                     a_d     = A_E;
                     b_d     = B_E;
                  end
                  OpMthi:  hi_d = A_E;
                  OpMtlo:  lo_d = A_E;
                  default: ;
               endcase
            end
         end
         StRun: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StIdle;
               if (op_q == OpMult || op_q == OpMultu) begin
                  hi_d = prod[63:32];
                  lo_d = prod[31:0];
               end else if (!b_zero) begin
                  hi_d = rem;
                  lo_d = quot;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         op_q    <= 3'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      start_md = Start_E && (MDOp_E == OpMult || MDOp_E == OpMultu ||
                             MDOp_E == OpDiv  || MDOp_E == OpDivu);
      Busy     = (state_q == StRun);
      HI       = hi_q;
      LO       = lo_q;
      Stall_MD = MD_D & (Busy | start_md);
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: per-cycle comparison against an arithmetic reference model,
// directed literal checks from the test plan, then randomized traffic.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  MDOp_E;
   logic        Start_E;
   logic [31:0] A_E, B_E;
   logic        MD_D;
   logic        Busy, Stall_MD;
   logic [31:0] HI, LO;

   int n_cmp = 0;
   int n_fail = 0;
   int n_ignored = 0;
   bit check_en = 1'b0;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .MDOp_E   (MDOp_E),
      .Start_E  (Start_E),
      .A_E      (A_E),
      .B_E      (B_E),
      .MD_D     (MD_D),
      .Busy     (Busy),
      .HI       (HI),
      .LO       (LO),
      .Stall_MD (Stall_MD)
   );

   always #5 clk = ~clk;

   // Reference model: result is computed at acceptance and lands at a fixed edge index.
   longint      edge_no = 0;
   longint      done_at = 0;
   bit          m_pend = 1'b0;
   bit          m_wr = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;

   function automatic bit is_md(input logic [2:0] op);
      return op >= 3'd1 && op <= 3'd4;
   endfunction

   always @(posedge clk) begin
      bit          was_busy;
      logic [63:0] p;
      longint      q, r;
      edge_no++;
      if (reset) begin
         m_pend = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
      end else begin
         was_busy = m_pend;
         if (m_pend && edge_no == done_at) begin
            m_pend = 1'b0;
            if (m_wr) begin
               m_hi = m_rhi;
               m_lo = m_rlo;
            end
         end
         if (Start_E && was_busy) begin
            n_ignored++;
         end else if (Start_E) begin
            m_wr = 1'b1;
            case (MDOp_E)
               3'd1: p = 64'(longint'($signed(A_E)) * longint'($signed(B_E)));
               3'd2: p = {32'd0, A_E} * {32'd0, B_E};
               3'd3: begin
                  if (B_E == 0) m_wr = 1'b0;
                  else begin
                     q = longint'($signed(A_E)) / longint'($signed(B_E));
                     r = longint'($signed(A_E)) % longint'($signed(B_E));
                     p = {r[31:0], q[31:0]};
                  end
               end
               3'd4: begin
                  if (B_E == 0) m_wr = 1'b0;
                  else p = {A_E % B_E, A_E / B_E};
               end
               3'd5: m_hi = A_E;
               3'd6: m_lo = A_E;
               default: ;
            endcase
            if (is_md(MDOp_E)) begin
               m_pend  = 1'b1;
               done_at = edge_no + ((MDOp_E <= 3'd2) ? 5 : 10);
               m_rhi   = p[63:32];
               m_rlo   = p[31:0];
            end
         end
      end
   end

   always @(negedge clk) begin
      logic exp_stall;
      if (check_en) begin
         exp_stall = MD_D & (m_pend | (Start_E & is_md(MDOp_E)));
         n_cmp += 4;
         if (Busy !== m_pend) begin
            n_fail++;
            $display("FAIL model_busy t=%0t got %b want %b", $time, Busy, m_pend);
         end
         if (HI !== m_hi) begin
            n_fail++;
            $display("FAIL model_hi t=%0t got %h want %h", $time, HI, m_hi);
         end
         if (LO !== m_lo) begin
            n_fail++;
            $display("FAIL model_lo t=%0t got %h want %h", $time, LO, m_lo);
         end
         if (Stall_MD !== exp_stall) begin
            n_fail++;
            $display("FAIL model_stall t=%0t got %b want %b", $time, Stall_MD, exp_stall);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   // Issues one op at cycle 0 and checks busy window and final HI/LO literally.
   task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [31:0] eh,
                         input logic [31:0] el);
      MDOp_E  = op;
      A_E     = a;
      B_E     = b;
      Start_E = 1'b1;
      tick();
      Start_E = 1'b0;
      MDOp_E  = 3'd0;
      for (int k = 1; k <= n; k++) begin
         chk({nm, "_busy"}, 32'(Busy), 32'd1);
         tick();
      end
      chk({nm, "_idle"}, 32'(Busy), 32'd0);
      chk({nm, "_hi"}, HI, eh);
      chk({nm, "_lo"}, LO, el);
   endtask

   initial begin
      reset   = 1'b1;
      MDOp_E  = 3'd0;
      Start_E = 1'b0;
      A_E     = '0;
      B_E     = '0;
      MD_D    = 1'b0;
      tick();
      tick();
      check_en = 1'b1;
      chk("reset_busy", 32'(Busy), 32'd0);
      chk("reset_hi", HI, 32'd0);
      chk("reset_lo", LO, 32'd0);
      reset = 1'b0;

      run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'h2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'h2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
      run_op("div", 3'd3, 32'hFFFF_FFF9, 32'h2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
      run_op("div_wrap", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

      // Stall covers the start cycle and all busy cycles.
      MD_D    = 1'b1;
      MDOp_E  = 3'd3;
      A_E     = 32'd100;
      B_E     = 32'd7;
      Start_E = 1'b1;
      #1 chk("stall_start", 32'(Stall_MD), 32'd1);
      tick();
      Start_E = 1'b0;
      MDOp_E  = 3'd0;
      for (int k = 1; k <= 10; k++) begin
         chk("stall_busy", 32'(Stall_MD), 32'd1);
         tick();
      end
      chk("stall_release", 32'(Stall_MD), 32'd0);
      chk("stall_div_lo", LO, 32'd14);
      chk("stall_div_hi", HI, 32'd2);
      MD_D = 1'b0;
      MDOp_E  = 3'd3;
      Start_E = 1'b1;
      #1 chk("nostall_start", 32'(Stall_MD), 32'd0);
      Start_E = 1'b0;
      MDOp_E  = 3'd0;

      // mthi then mtlo on consecutive cycles, never busy.
      MDOp_E  = 3'd5;
      A_E     = 32'h1234_5678;
      Start_E = 1'b1;
      tick();
      chk("mthi_hi", HI, 32'h1234_5678);
      chk("mthi_busy", 32'(Busy), 32'd0);
      MDOp_E = 3'd6;
      A_E    = 32'h9ABC_DEF0;
      tick();
      Start_E = 1'b0;
      MDOp_E  = 3'd0;
      chk("mtlo_lo", LO, 32'h9ABC_DEF0);
      chk("mtlo_busy", 32'(Busy), 32'd0);
      run_op("divu_by0", 3'd4, 32'd55, 32'd0, 10, 32'h1234_5678, 32'h9ABC_DEF0);

      // Reset in cycle 3 of a mult with a coincident start.
      MDOp_E  = 3'd1;
      A_E     = 32'd9;
      B_E     = 32'd9;
      Start_E = 1'b1;
      tick();
      Start_E = 1'b0;
      tick();
      tick();
      reset   = 1'b1;
      Start_E = 1'b1;
      tick();
      reset   = 1'b0;
      Start_E = 1'b0;
      MDOp_E  = 3'd0;
      chk("rst_abort_busy", 32'(Busy), 32'd0);
      chk("rst_abort_hi", HI, 32'd0);
      chk("rst_abort_lo", LO, 32'd0);

      // Start issued mid-run is ignored; original result lands on schedule.
      MDOp_E  = 3'd1;
      A_E     = 32'd3;
      B_E     = 32'd5;
      Start_E = 1'b1;
      tick();
      Start_E = 1'b0;
      tick();
      MDOp_E  = 3'd3;
      A_E     = 32'd77;
      B_E     = 32'd4;
      Start_E = 1'b1;
      tick();
      Start_E = 1'b0;
      MDOp_E  = 3'd0;
      tick();
      tick();
      chk("ignore_busy5", 32'(Busy), 32'd1);
      tick();
      chk("ignore_busy6", 32'(Busy), 32'd0);
      chk("ignore_lo", LO, 32'd15);
      chk("ignore_hi", HI, 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         reset   = ($urandom_range(0, 199) == 0);
         Start_E = ($urandom_range(0, 3) == 0);
         MDOp_E  = 3'($urandom_range(0, 7));
         MD_D    = 1'($urandom_range(0, 1));
         A_E     = $urandom;
         B_E     = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 31) == 0) begin
            A_E = 32'h8000_0000;
            B_E = 32'hFFFF_FFFF;
         end
         tick();
      end
      reset   = 1'b0;
      Start_E = 1'b0;
      tick();
      tick();

      $display("note: %0d start pulses issued while busy were ignored", n_ignored);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
